// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment driver: shadow-latches DIGITS nibbles and decimal points, then
// scans them onto a shared segment bus with one-hot anodes, dead time and leading-zero blanking.
module seg7_scan_driver #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned SCAN_DIV   = 16,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  le,
    input  logic [DIGITS-1:0]     en,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  seg_p,
    output logic [DIGITS-1:0]     an,
    output logic [2:0]            digit_idx
);

    localparam int unsigned    CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [2:0]     IDX_LAST = 3'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [2:0]          idx;
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;

    logic [3:0]          nib;
    logic                dp_bit;
    logic                upper_nz;
    logic [6:0]          seg_hi;
    logic [DIGITS-1:0]   an_hi;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Digit selection is done by comparison rather than variable indexing so DIGITS=1 stays clean.
    always_comb begin
        nib      = '0;
        dp_bit   = 1'b0;
        upper_nz = 1'b0;
        an_hi    = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (3'(i) == idx) begin
                nib      = sh_data[4*i +: 4];
                dp_bit   = sh_dp[i];
                an_hi[i] = en[i] && (cnt != '0);
            end
            if (3'(i) >= idx && sh_data[4*i +: 4] != 4'h0) begin
                upper_nz = 1'b1;
            end
        end
        seg_hi = (blank_lz && idx != 3'd0 && !upper_nz) ? 7'h00 : hex_decode(nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            sh_data   <= '0;
            sh_dp     <= '0;
            seg       <= {7{ACTIVE_LOW}};
            seg_p     <= ACTIVE_LOW;
            an        <= {DIGITS{ACTIVE_LOW}};
            digit_idx <= '0;
        end else begin
            if (!le) begin
                sh_data <= data;
                sh_dp   <= dp;
            end
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            seg       <= seg_hi ^ {7{ACTIVE_LOW}};
            seg_p     <= dp_bit ^ ACTIVE_LOW;
            an        <= an_hi ^ {DIGITS{ACTIVE_LOW}};
            digit_idx <= idx;
        end
    end

endmodule
